ps2_key_event_decoder: RTL and testbench
========================================

// Module: ps2_key_event_decoder
// PURPOSE
//  Next-generation PS/2 set-2 scan-code decoder. Sits after the PS/2 byte receiver and before the display/CPU side.
//  Parses make, break and E0-extended sequences, tracks modifiers and Caps Lock, and filters typematic repeats.
//  Queues complete key events, with an ASCII translation, in a FWFT FIFO drained by a valid/ready handshake.
// PARAMETERS
//  FIFO_DEPTH     8   event FIFO entries; power of 2, >=2
//  CNT_W          8   width of key_cnt
//  FILTER_REPEAT  1   1: drop repeated make of the currently held key; 0: queue every make
// PORTS
//  clk            in   1   system clock, all logic on posedge
//  rst            in   1   synchronous, active-low reset
//  ps2_data       in   8   received scan-code byte, valid when ps2_valid=1
//  ps2_valid      in   1   one-cycle strobe per received byte
//  evt_valid      out  1   FIFO non-empty; head event on evt_* outputs
//  evt_ready      in   1   consumer pops head when evt_valid&evt_ready
//  evt_code       out  8   head: final scan code (without E0/F0 prefixes)
//  evt_ext        out  1   head: sequence carried an E0 prefix
//  evt_break      out  1   head: 1=release, 0=press
//  evt_ascii      out  8   head: ASCII for printable non-ext make events, else 8'h00
//  fifo_level     out  $clog2(FIFO_DEPTH)+1   current occupancy
//  overflow       out  1   sticky: an event was dropped because the FIFO was full
//  key_cnt        out  CNT_W  count of queued break events; wraps
//  shift_flag     out  1   left (12) OR right (59) shift held
//  ctrl_flag      out  1   ctrl (14 or E0 14) held
//  alt_flag       out  1   alt (11 or E0 11) held
//  caps_flag      out  1   Caps Lock toggle state
// BEHAVIOUR
//  Reset (rst=0 at posedge): parser->IDLE, FIFO empty, every output 0, held-key register cleared; this aborts any partial sequence.
//  Parser FSM advances only on ps2_valid=1; it holds otherwise.
//   IDLE:    E0->EXT; F0->BRK; FA/AA/EE/FE discarded; other byte b -> make event (b, ext=0), stay IDLE.
//   EXT:     F0->EXT_BRK; other b -> make event (b, ext=1) -> IDLE.
//   BRK:     b -> break event (b, ext=0) -> IDLE.
//   EXT_BRK: b -> break event (b, ext=1) -> IDLE.
//  Events complete in the cycle of their final byte; the push takes effect at that posedge.
//   With the FIFO empty, evt_valid rises on the following cycle (latency 1).
//  Held key {ext,code}: set on an accepted make event, cleared on a break of the same {ext,code}.
//   If FILTER_REPEAT=1, a make equal to the held key is dropped (no push, no modifier or caps change).
//  Modifiers update at the event's posedge (make sets, break clears): lshift 12, rshift 59, ctrl 14, alt 11.
//   Ext 12/59 (fake shifts) are ignored for flags but still queued.
//  Caps toggles on each non-filtered non-ext make of 58.
//  ASCII, non-ext make events only, using modifier and caps values before this event's update:
//   Letters 1C..1A map to a..z; uppercase when shift_flag XOR caps_flag.
//   Digits 16,1E,26,25,2E,36,3D,3E,46,45 map to '1'..'9','0' regardless of shift.
//   29 maps to 20, 5A to 0D, 66 to 08; all other codes give 00.
//  FIFO behaviour:
//   Push when full: the event is dropped and overflow is set until reset. The push counts as accepted if a pop occurs in the same cycle.
//   Push and pop in the same cycle: fifo_level is unchanged.
//   Empty: evt_valid=0, and evt_* hold their last value.
//   Pointers wrap modulo FIFO_DEPTH.
//  key_cnt increments only for break events actually pushed; it wraps from all-ones to 0.
//  ctrl/alt do not alter evt_ascii.
// TESTING
//  1C; F0 1C -> two events {1C,ext0,brk0,61} then {1C,ext0,brk1,00}; key_cnt=1.
//  12; 1C; F0 1C; F0 12 -> make 1C gives ascii 41; shift_flag 1 then 0; 4 events queued.
//  58 F0 58; 1C -> caps_flag=1, ascii 41; then 12; 1C -> ascii 61 (shift XOR caps).
//  E0 75; E0 F0 75 -> {75,ext1,brk0,00} and {75,ext1,brk1,00}; 1C 1C 1C -> one event (FILTER_REPEAT=1).
//  evt_ready=0, push FIFO_DEPTH+1 makes -> fifo_level=8, overflow=1; simultaneous push+pop at full -> level stays 8.
//  F0 received, then rst=0 for one cycle, then 1C -> single make event 1C; no break event appears.

Source files
------------

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 scan-code decoder: parses make/break/E0 sequences, tracks modifiers
// and Caps Lock, filters typematic repeats and queues key events in a FWFT FIFO.
module ps2_key_event_decoder #(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned CNT_W         = 8,
    parameter bit          FILTER_REPEAT = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    ps2_data,
    input  logic                          ps2_valid,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic [7:0]                    evt_ascii,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [CNT_W-1:0]              key_cnt,
    output logic                          shift_flag,
    output logic                          ctrl_flag,
    output logic                          alt_flag,
    output logic                          caps_flag
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [AW:0]      LVL_ONE = (AW + 1)'(1);
    localparam logic [AW:0]      LVL_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
    } event_t;

    state_t state_q, state_d;

    logic       ev_fire;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic [8:0] ev_key;
    logic       repeat_hit;
    logic       ev_take;
    logic       push;
    logic       pop;
    logic       drop;
    logic       full;
    event_t     ev_entry;
    event_t     head;
    event_t     last_q;
    event_t     mem [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          held_v;
    logic [8:0]    held_key;
    logic          lshift, rshift, lctrl, rctrl, lalt, ralt, caps_q;

    function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic upper);
        logic [7:0] a;
        logic       letter;
        letter = 1'b1;
        case (code)
            8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
            8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
            8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
            8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
            8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
            default: begin
                letter = 1'b0;
                case (code)
                    8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;  8'h25: a = 8'h34;
                    8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;  8'h3E: a = 8'h38;
                    8'h46: a = 8'h39;  8'h45: a = 8'h30;
                    8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
                    default: a = 8'h00;
                endcase
            end
        endcase
        if (letter && upper) begin
            a = a - 8'h20;
        end
        return a;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ev_fire = 1'b0;
        ev_code = ps2_data;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        if (ps2_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (ps2_data == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (ps2_data == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (!(ps2_data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE})) begin
                        ev_fire = 1'b1;
                    end
                end
                S_EXT: begin
                    if (ps2_data == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        ev_fire = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    ev_fire = 1'b1;
                    ev_brk  = 1'b1;
                    state_d = S_IDLE;
                end
                S_EXT_BRK: begin
                    ev_fire = 1'b1;
                    ev_ext  = 1'b1;
                    ev_brk  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign ev_key     = {ev_ext, ev_code};
    assign repeat_hit = FILTER_REPEAT && held_v && (held_key == ev_key) && !ev_brk;
    assign ev_take    = ev_fire && !repeat_hit;

    assign evt_valid  = (level_q != '0);
    assign full       = (level_q == LVL_FULL);
    assign pop        = evt_valid && evt_ready;
    // A full FIFO still accepts the event when the head leaves in the same cycle.
    assign push       = ev_take && (!full || pop);
    assign drop       = ev_take && full && !pop;

    always_comb begin
        ev_entry.code  = ev_code;
        ev_entry.ext   = ev_ext;
        ev_entry.brk   = ev_brk;
        ev_entry.ascii = (!ev_ext && !ev_brk) ? to_ascii(ev_code, shift_flag ^ caps_q) : 8'h00;
    end

    // When empty the outputs show the most recently popped event.
    assign head       = evt_valid ? mem[rd_ptr] : last_q;
    assign evt_code   = head.code;
    assign evt_ext    = head.ext;
    assign evt_break  = head.brk;
    assign evt_ascii  = head.ascii;
    assign fifo_level = level_q;

    assign shift_flag = lshift | rshift;
    assign ctrl_flag  = lctrl | rctrl;
    assign alt_flag   = lalt | ralt;
    assign caps_flag  = caps_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ev_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            last_q   <= '0;
            overflow <= 1'b0;
            key_cnt  <= '0;
        end else begin
            if (pop) begin
                last_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                level_q <= level_q + LVL_ONE;
            end else if (pop && !push) begin
                level_q <= level_q - LVL_ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (push && ev_brk) begin
                key_cnt <= key_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            held_v   <= 1'b0;
            held_key <= '0;
            lshift   <= 1'b0;
            rshift   <= 1'b0;
            lctrl    <= 1'b0;
            rctrl    <= 1'b0;
            lalt     <= 1'b0;
            ralt     <= 1'b0;
            caps_q   <= 1'b0;
        end else if (ev_take) begin
            if (!ev_brk) begin
                held_v   <= 1'b1;
                held_key <= ev_key;
            end else if (held_v && held_key == ev_key) begin
                held_v <= 1'b0;
            end
            if (!ev_ext) begin
                case (ev_code)
                    8'h12: lshift <= !ev_brk;
                    8'h59: rshift <= !ev_brk;
                    8'h14: lctrl  <= !ev_brk;
                    8'h11: lalt   <= !ev_brk;
                    8'h58: if (!ev_brk) caps_q <= !caps_q;
                    default: ;
                endcase
            end else begin
                case (ev_code)
                    8'h14: rctrl <= !ev_brk;
                    8'h11: ralt  <= !ev_brk;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: a queue-based event model checked every cycle,
// plus literal expectations on the directed scenarios.
module tb_ps2_key_event_decoder;

    localparam int DEPTH = 8;
    localparam int CW    = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ps2_data;
    logic       ps2_valid;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [7:0] evt_ascii;
    logic [3:0] fifo_level;
    logic       overflow;
    logic [7:0] key_cnt;
    logic       shift_flag, ctrl_flag, alt_flag, caps_flag;

    ps2_key_event_decoder #(
        .FIFO_DEPTH(DEPTH),
        .CNT_W(CW),
        .FILTER_REPEAT(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_break(evt_break), .evt_ascii(evt_ascii),
        .fifo_level(fifo_level), .overflow(overflow), .key_cnt(key_cnt),
        .shift_flag(shift_flag), .ctrl_flag(ctrl_flag), .alt_flag(alt_flag),
        .caps_flag(caps_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
    } ev_t;

    localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
        8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15,
        8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGITS [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46, 8'h45};

    ev_t  mq[$];
    ev_t  mlast;
    bit   pressed [512];
    bit   m_e0, m_f0, m_held_v, m_caps, m_ovf, m_pop;
    logic [8:0] m_held;
    int   m_kcnt;

    function automatic bit m_shift();
        return pressed[9'h012] | pressed[9'h059];
    endfunction
    function automatic bit m_ctrl();
        return pressed[9'h014] | pressed[9'h114];
    endfunction
    function automatic bit m_alt();
        return pressed[9'h011] | pressed[9'h111];
    endfunction

    function automatic logic [7:0] ascii_of(input logic [7:0] c, input bit up);
        for (int i = 0; i < 26; i++)
            if (LETTERS[i] == c) return (up ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (DIGITS[i] == c) return (i == 9) ? 8'h30 : 8'h31 + 8'(i);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        if (c == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    task automatic model_event(input logic [7:0] code, input bit ext, input bit brk);
        logic [8:0] key;
        ev_t ev;
        key = {ext, code};
        if (!brk && m_held_v && m_held == key) return;
        ev.code  = code;
        ev.ext   = ext;
        ev.brk   = brk;
        ev.ascii = (!ext && !brk) ? ascii_of(code, m_shift() ^ m_caps) : 8'h00;
        if (mq.size() < DEPTH) begin
            mq.push_back(ev);
            if (brk) m_kcnt = (m_kcnt + 1) % (1 << CW);
        end else begin
            m_ovf = 1'b1;
        end
        if (!brk) begin
            m_held_v = 1'b1;
            m_held   = key;
        end else if (m_held_v && m_held == key) begin
            m_held_v = 1'b0;
        end
        pressed[key] = !brk;
        if (!ext && !brk && code == 8'h58) m_caps = !m_caps;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_e0 && !m_f0 && b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE}) return;
        if (b == 8'hF0 && !m_f0) begin
            m_f0 = 1'b1;
            return;
        end
        if (b == 8'hE0 && !m_e0 && !m_f0) begin
            m_e0 = 1'b1;
            return;
        end
        model_event(b, m_e0, m_f0);
        m_e0 = 1'b0;
        m_f0 = 1'b0;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
            mlast = '{8'h00, 1'b0, 1'b0, 8'h00};
            foreach (pressed[i]) pressed[i] = 1'b0;
            m_e0 = 0; m_f0 = 0; m_held_v = 0; m_held = '0;
            m_caps = 0; m_ovf = 0; m_kcnt = 0;
        end else begin
            m_pop = evt_ready && mq.size() > 0;
            if (m_pop) mlast = mq.pop_front();
            if (ps2_valid) model_byte(ps2_data);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            ev_t h;
            h = (mq.size() > 0) ? mq[0] : mlast;
            chk("evt_valid",  32'(evt_valid),  32'(mq.size() > 0));
            chk("evt_code",   32'(evt_code),   32'(h.code));
            chk("evt_ext",    32'(evt_ext),    32'(h.ext));
            chk("evt_break",  32'(evt_break),  32'(h.brk));
            chk("evt_ascii",  32'(evt_ascii),  32'(h.ascii));
            chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
            chk("overflow",   32'(overflow),   32'(m_ovf));
            chk("key_cnt",    32'(key_cnt),    32'(m_kcnt));
            chk("shift_flag", 32'(shift_flag), 32'(m_shift()));
            chk("ctrl_flag",  32'(ctrl_flag),  32'(m_ctrl()));
            chk("alt_flag",   32'(alt_flag),   32'(m_alt()));
            chk("caps_flag",  32'(caps_flag),  32'(m_caps));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        ps2_data  = b;
        ps2_valid = 1'b1;
        @(posedge clk); #1;
        ps2_valid = 1'b0;
    endtask

    task automatic send_pop(input logic [7:0] b);
        evt_ready = 1'b1;
        send(b);
        evt_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pop1();
        evt_ready = 1'b1;
        @(posedge clk); #1;
        evt_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; ps2_valid = 1'b0; ps2_data = 8'h00; evt_ready = 1'b0;
        idle(2);
        rst = 1'b1;
        chk_en = 1'b1;
        chk("reset_valid", 32'(evt_valid), 32'h0);
        chk("reset_level", 32'(fifo_level), 32'h0);

        // make + break of 'a'
        send(8'h1C); send(8'hF0); send(8'h1C); idle(1);
        chk("t1_level", 32'(fifo_level), 32'd2);
        chk("t1_head", {evt_code, 7'b0, evt_ext, 7'b0, evt_break, evt_ascii}, 32'h1C000061);
        chk("t1_kcnt", 32'(key_cnt), 32'd1);
        pop1();
        chk("t1_head2", {evt_code, 7'b0, evt_ext, 7'b0, evt_break, evt_ascii}, 32'h1C000100);
        pop1();
        chk("t1_empty_hold", 32'(evt_code), 32'h1C);

        // shifted letter
        do_reset();
        send(8'h12); idle(1);
        chk("t2_shift_on", 32'(shift_flag), 32'd1);
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); idle(1);
        chk("t2_shift_off", 32'(shift_flag), 32'd0);
        chk("t2_level", 32'(fifo_level), 32'd4);
        pop1();
        chk("t2_ascii_A", 32'(evt_ascii), 32'h41);

        // caps lock and shift XOR caps
        do_reset();
        send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
        send(8'h12); send(8'h1C); idle(1);
        chk("t3_caps", 32'(caps_flag), 32'd1);
        chk("t3_level", 32'(fifo_level), 32'd5);
        pop1(); pop1();
        chk("t3_ascii_caps", 32'(evt_ascii), 32'h41);
        pop1(); pop1();
        chk("t3_ascii_xor", 32'(evt_ascii), 32'h61);

        // extended key and repeat filter
        do_reset();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h1C); send(8'h1C); send(8'h1C); idle(1);
        chk("t4_level", 32'(fifo_level), 32'd3);
        chk("t4_head", {evt_code, 7'b0, evt_ext, 7'b0, evt_break, evt_ascii}, 32'h75010000);
        chk("t4_kcnt", 32'(key_cnt), 32'd1);

        // overflow and push+pop at full
        do_reset();
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
        send(8'h35); send(8'h3C); send(8'h43); send(8'h44); idle(1);
        chk("t5_level_full", 32'(fifo_level), 32'd8);
        chk("t5_overflow", 32'(overflow), 32'd1);
        send_pop(8'h4D); idle(1);
        chk("t5_level_pushpop", 32'(fifo_level), 32'd8);
        repeat (10) pop1();

        // reset aborts a pending break prefix
        send(8'hF0);
        do_reset();
        send(8'h1C); idle(1);
        chk("t6_level", 32'(fifo_level), 32'd1);
        chk("t6_head", {evt_code, 7'b0, evt_break}, 32'h1C00);

        // digits, specials, discard, fake shift, ctrl/alt
        do_reset();
        send(8'h12); send(8'h16); send(8'h29); send(8'h5A); send(8'h66);
        send(8'h45); send(8'hFA); idle(1);
        chk("t7_level", 32'(fifo_level), 32'd6);
        pop1();
        chk("t7_digit", 32'(evt_ascii), 32'h31);
        repeat (8) pop1();
        send(8'hF0); send(8'h12);
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h14); send(8'h11); idle(1);
        chk("t7_fake_shift", 32'(shift_flag), 32'd0);
        chk("t7_ctrl_alt", {ctrl_flag, alt_flag}, 32'd3);
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C); idle(1);
        repeat (8) pop1();

        // key_cnt wrap
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            send(8'hF0); send(8'h1C);
        end
        idle(1);
        chk("t8_kcnt_ff", 32'(key_cnt), 32'hFF);
        send(8'hF0); send(8'h1C); idle(1);
        chk("t8_kcnt_wrap", 32'(key_cnt), 32'h0);
        evt_ready = 1'b0;
        idle(2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
